// File: rtl/cam_rgb565_unpacker.sv
// RGB565 camera byte stream to 8-bit RGB pixels with x/y position.
// Optional macro CAM_BITREPL_EN: bit-replication expansion (default zero-fill).
module cam_rgb565_unpacker #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int XW         = 10,
  parameter int YW         = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    cam_data_i,
  input  logic          cam_byte_vld_i,
  input  logic          cam_href_i,
  input  logic          cam_vsync_i,
  output logic [7:0]    red_o,
  output logic [7:0]    green_o,
  output logic [7:0]    blue_o,
  output logic          cam_done_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          frame_done_o,
  output logic          line_err_o
);

  typedef enum logic [1:0] {
    IDLE,
    VBLANK,
    ACTIVE
  } state_t;

  // counters carry one extra bit so they can hold IMG_WIDTH/IMG_HEIGHT
  localparam logic [XW:0] W_C = (XW+1)'(IMG_WIDTH);
  localparam logic [YW:0] H_C = (YW+1)'(IMG_HEIGHT);

  state_t      state_q, state_d;
  logic        href_q, vsync_q;
  logic        phase_q, phase_d;
  logic [7:0]  byte_q, byte_d;
  logic [XW:0] col_q, col_d;
  logic [YW:0] row_q, row_d;
  logic [7:0]  red_q, red_d;
  logic [7:0]  grn_q, grn_d;
  logic [7:0]  blu_q, blu_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic        done_q, done_d;
  logic        fd_q, fd_d;
  logic        err_q, err_d;

  logic        href_fall, vs_rise, byte_ok;
  logic [4:0]  r5, b5;
  logic [5:0]  g6;
  logic [7:0]  r8, g8, b8;

  assign href_fall = href_q & ~cam_href_i;
  assign vs_rise   = cam_vsync_i & ~vsync_q;
  assign byte_ok   = cam_byte_vld_i & cam_href_i;

  assign r5 = byte_q[7:3];
  assign g6 = {byte_q[2:0], cam_data_i[7:5]};
  assign b5 = cam_data_i[4:0];

`ifdef CAM_BITREPL_EN
  assign r8 = {r5, r5[4:2]};
  assign g8 = {g6, g6[5:4]};
  assign b8 = {b5, b5[4:2]};
`else
  assign r8 = {r5, 3'b000};
  assign g8 = {g6, 2'b00};
  assign b8 = {b5, 3'b000};
`endif

  // frame FSM, byte pairing, position tracking and error flag
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    byte_d  = byte_q;
    col_d   = col_q;
    row_d   = row_q;
    red_d   = red_q;
    grn_d   = grn_q;
    blu_d   = blu_q;
    x_d     = x_q;
    y_d     = y_q;
    done_d  = 1'b0;
    fd_d    = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (cam_vsync_i) state_d = VBLANK;
      end
      VBLANK: begin
        if (!cam_vsync_i) begin
          state_d = ACTIVE;
          col_d   = '0;
          row_d   = '0;
          phase_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      ACTIVE: begin
        if (vs_rise) begin
          state_d = VBLANK;
          fd_d    = 1'b1;
          phase_d = 1'b0;
          if (row_q < H_C) err_d = 1'b1;
        end else begin
          if (byte_ok) begin
            if (!phase_q) begin
              byte_d  = cam_data_i;
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              if (col_q < W_C && row_q < H_C) begin
                red_d  = r8;
                grn_d  = g8;
                blu_d  = b8;
                x_d    = col_q[XW-1:0];
                y_d    = row_q[YW-1:0];
                done_d = 1'b1;
                col_d  = col_q + 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
          end
          if (href_fall) begin
            if (phase_q) err_d = 1'b1;
            if (col_q != W_C) err_d = 1'b1;
            phase_d = 1'b0;
            col_d   = '0;
            if (row_q < H_C) row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      href_q  <= 1'b0;
      vsync_q <= 1'b0;
      phase_q <= 1'b0;
      byte_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      red_q   <= '0;
      grn_q   <= '0;
      blu_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      href_q  <= cam_href_i;
      vsync_q <= cam_vsync_i;
      phase_q <= phase_d;
      byte_q  <= byte_d;
      col_q   <= col_d;
      row_q   <= row_d;
      red_q   <= red_d;
      grn_q   <= grn_d;
      blu_q   <= blu_d;
      x_q     <= x_d;
      y_q     <= y_d;
      done_q  <= done_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
    end
  end

  assign red_o        = red_q;
  assign green_o      = grn_q;
  assign blue_o       = blu_q;
  assign x_o          = x_q;
  assign y_o          = y_q;
  assign cam_done_o   = done_q;
  assign frame_done_o = fd_q;
  assign line_err_o   = err_q;

endmodule

// File: tb/tb_cam_rgb565_unpacker.sv
// Directed bench for cam_rgb565_unpacker on a 4x3 image.
// Expected colours follow CAM_BITREPL_EN when defined.
module tb_cam_rgb565_unpacker;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int XW = 2;
  localparam int YW = 2;

`ifdef CAM_BITREPL_EN
  localparam int R_FS  = 255;
  localparam int G_FS  = 255;
  localparam int B_FS  = 255;
  localparam int G_MID = 69;
  localparam int B_MID = 165;
`else
  localparam int R_FS  = 248;
  localparam int G_FS  = 252;
  localparam int B_FS  = 248;
  localparam int G_MID = 68;
  localparam int B_MID = 160;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    data;
  logic          vld;
  logic          href;
  logic          vsync;
  logic [7:0]    red, green, blue;
  logic          done;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          fd;
  logic          err;

  int checks   = 0;
  int failures = 0;
  int n_done   = 0;
  int n_fd     = 0;
  int b0, f0;

  cam_rgb565_unpacker #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .XW        (XW),
    .YW        (YW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cam_data_i    (data),
    .cam_byte_vld_i(vld),
    .cam_href_i    (href),
    .cam_vsync_i   (vsync),
    .red_o         (red),
    .green_o       (green),
    .blue_o        (blue),
    .cam_done_o    (done),
    .x_o           (x),
    .y_o           (y),
    .frame_done_o  (fd),
    .line_err_o    (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) n_done++;
    if (fd) n_fd++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic byte_(input logic [7:0] d);
    tick();
    data = d;
    vld  = 1'b1;
  endtask

  task automatic idle_();
    tick();
    vld = 1'b0;
  endtask

  task automatic vs_cycle();
    tick();
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic line(input int nb, input logic [7:0] base);
    tick();
    href = 1'b1;
    for (int i = 0; i < nb; i++) byte_(base + 8'(i * 17));
    idle_();
    tick();
    href = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; href = 1'b0;
    vsync = 1'b0; data = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_red", red, 0);
    chk("rst_green", green, 0);
    chk("rst_blue", blue, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_done", done, 0);
    chk("rst_fd", fd, 0);
    chk("rst_err", err, 0);

    // full frame, first line hand-checked
    vs_cycle();
    b0 = n_done; f0 = n_fd;
    tick();
    href = 1'b1;
    byte_(8'hF8);
    byte_(8'h00);
    chk("lat_p0_early", done, 0);
    byte_(8'h07);
    chk("p0_done", done, 1);
    chk("p0_red", red, R_FS);
    chk("p0_green", green, 0);
    chk("p0_blue", blue, 0);
    chk("p0_x", x, 0);
    chk("p0_y", y, 0);
    byte_(8'hE0);
    chk("lat_p1_early", done, 0);
    byte_(8'h12);
    chk("p1_done", done, 1);
    chk("p1_red", red, 0);
    chk("p1_green", green, G_FS);
    chk("p1_x", x, 1);
    byte_(8'h34);
    byte_(8'hFF);
    chk("p2_red", red, 16);
    chk("p2_green", green, G_MID);
    chk("p2_blue", blue, B_MID);
    chk("p2_x", x, 2);
    byte_(8'hFF);
    idle_();
    chk("p3_done", done, 1);
    chk("p3_red", red, R_FS);
    chk("p3_green", green, G_FS);
    chk("p3_blue", blue, B_FS);
    chk("p3_x", x, 3);
    idle_();
    chk("p3_pulse", done, 0);
    chk("hold_red", red, R_FS);
    tick();
    href = 1'b0;
    repeat (3) tick();
    chk("line0_err", err, 0);
    line(8, 8'h21);
    line(8, 8'h43);
    tick();
    vsync = 1'b1;
    tick();
    chk("fd_pulse", fd, 1);
    tick();
    chk("fd_one", fd, 0);
    chk("frame_pix", n_done - b0, 12);
    chk("last_x", x, 3);
    chk("last_y", y, 2);
    chk("frame_err", err, 0);
    chk("frame_fds", n_fd - f0, 1);
    repeat (3) tick();
    vsync = 1'b0;
    repeat (3) tick();

    // odd byte count
    b0 = n_done;
    tick();
    href = 1'b1;
    byte_(8'h12);
    byte_(8'h34);
    byte_(8'h56);
    idle_();
    tick();
    href = 1'b0;
    repeat (3) tick();
    chk("odd_pix", n_done - b0, 1);
    chk("odd_err", err, 1);
    tick();
    href = 1'b1;
    byte_(8'hF8);
    byte_(8'h00);
    idle_();
    chk("odd_next_done", done, 1);
    chk("odd_next_red", red, R_FS);
    chk("odd_next_x", x, 0);
    chk("odd_next_y", y, 1);
    tick();
    href = 1'b0;
    repeat (3) tick();

    // long line
    vs_cycle();
    chk("err_clear", err, 0);
    b0 = n_done;
    line(12, 8'h05);
    chk("long_pix", n_done - b0, 4);
    chk("long_err", err, 1);
    chk("long_x", x, 3);

    // early vsync
    vs_cycle();
    chk("err_clear2", err, 0);
    b0 = n_done;
    line(8, 8'h11);
    chk("early_l0_err", err, 0);
    tick();
    href = 1'b1;
    byte_(8'h12);
    byte_(8'h34);
    byte_(8'h56);
    idle_();
    chk("early_pre_err", err, 0);
    tick();
    vsync = 1'b1;
    tick();
    chk("early_fd", fd, 1);
    chk("early_err", err, 1);
    chk("early_pix", n_done - b0, 5);
    tick();
    href = 1'b0;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (3) tick();

    // reset mid-line
    b0 = n_done; f0 = n_fd;
    tick();
    href = 1'b1;
    byte_(8'h12);
    byte_(8'h34);
    byte_(8'h56);
    idle_();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_red", red, 0);
    chk("mr_green", green, 0);
    chk("mr_blue", blue, 0);
    chk("mr_done", done, 0);
    chk("mr_err", err, 0);
    chk("mr_fd", fd, 0);
    byte_(8'hF8);
    byte_(8'h00);
    idle_();
    repeat (2) tick();
    chk("mr_ignored", n_done - b0, 1);
    tick();
    href = 1'b0;
    vsync = 1'b1;
    repeat (3) tick();
    chk("mr_no_fd", n_fd - f0, 0);
    vsync = 1'b0;
    repeat (3) tick();
    tick();
    href = 1'b1;
    byte_(8'hF8);
    byte_(8'h00);
    idle_();
    chk("mr_resume_done", done, 1);
    chk("mr_resume_red", red, R_FS);
    chk("mr_resume_x", x, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
